// File: rtl/memq_pkg.sv
// memq_pkg: shared types and constants for the memory issue scheduler.
//  memq_entry_t  : one buffered load/store op (robid, wbs, flags, operand, addr, data)
//  memq_state_e  : issue FSM states
//  STORE_BIT     : flags bit that marks a store (1) versus a load (0)
//  MMIO_SW_LO/HI : switch MMIO addresses; such ops pass through untouched
package memq_pkg;

  localparam int         STORE_BIT  = 1;
  localparam logic [7:0] MMIO_SW_LO = 8'd254;
  localparam logic [7:0] MMIO_SW_HI = 8'd253;

  typedef struct packed {
    logic [3:0] robid;
    logic [7:0] wbs;
    logic [7:0] flags;
    logic [7:0] operand;
    logic [7:0] addr;
    logic [7:0] data;
  } memq_entry_t;

  localparam memq_entry_t ENTRY_ZERO = '{
    robid:   4'd0,
    wbs:     8'd0,
    flags:   8'd0,
    operand: 8'd0,
    addr:    8'd0,
    data:    8'd0
  };

  typedef enum logic [2:0] {
    EMPTY   = 3'd0,
    HEAD    = 3'd1,
    ST_WAIT = 3'd2,
    ISSUE   = 3'd3,
    COOL    = 3'd4
  } memq_state_e;

  // True when the entry is a store (must wait to become non-speculative).
  function automatic logic is_store(input memq_entry_t e);
    return e.flags[STORE_BIT];
  endfunction

endpackage

// File: rtl/memq_fifo.sv
// memq_fifo: DEPTH-entry circular buffer of memq_entry_t with occupancy count.
// Ports:
//  clk, rst (async active-low), flush (sync clear of pointers/count)
//  push/wr_entry : write request; ignored when full or flushing
//  pop           : release head entry; ignored when empty or flushing
//  rd_entry      : current head entry (valid when !empty)
//  count/full/empty : occupancy status
module memq_fifo
  import memq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  memq_entry_t      wr_entry,
  output memq_entry_t      rd_entry,
  output logic [OCC_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_ONE = OCC_W'(1);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(DEPTH);

  memq_entry_t      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [OCC_W-1:0] count_r;
  logic             full_s;
  logic             empty_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Status decode and accepted push/pop qualification.
  always_comb begin
    full_s    = (count_r == OCC_MAX);
    empty_s   = (count_r == {OCC_W{1'b0}});
    // A full queue never accepts, even if the head leaves on the same edge.
    push_ok_s = push && !full_s && !flush;
    pop_ok_s  = pop && !empty_s && !flush;
  end

  // Entry storage; only accepted pushes write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= ENTRY_ZERO;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_entry;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {OCC_W{1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {OCC_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + OCC_ONE;
        2'b01:   count_r <= count_r - OCC_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  assign rd_entry = mem_r[rd_ptr_r];
  assign count    = count_r;
  assign full     = full_s;
  assign empty    = empty_s;

endmodule

// File: rtl/mem_issue_sched.sv
// mem_issue_sched: in-order issue scheduler in front of the RAM functional unit.
// Buffers dispatched loads/stores and issues one op at a time to the FU.
// Loads issue as soon as they reach the head; stores wait until their ROB id
// is the ROB head. flush discards every buffered op.
// Ports:
//  clk, rst (async active-low), flush (sync squash)
//  in_valid/in_ready, in_robid, in_wbs, in_flags, in_operand, in_addr, in_data : dispatch side
//  rob_head_valid, rob_head_id : ROB head for store commit gating
//  fu_busy : FU stall; fu_transmit + fu_robid/wbs/flags/operand/depvals : issue side
//  count : occupancy; perf_st_wait / perf_fu_stall : perf counters
// Configuration: define MEMQ_PERF_EN to build the saturating perf counters;
// otherwise perf_st_wait and perf_fu_stall are tied to zero.
module mem_issue_sched
  import memq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 in_robid,
  input  logic [7:0]                 in_wbs,
  input  logic [7:0]                 in_flags,
  input  logic [7:0]                 in_operand,
  input  logic [7:0]                 in_addr,
  input  logic [7:0]                 in_data,
  input  logic                       rob_head_valid,
  input  logic [3:0]                 rob_head_id,
  input  logic                       fu_busy,
  output logic                       fu_transmit,
  output logic [3:0]                 fu_robid,
  output logic [7:0]                 fu_wbs,
  output logic [7:0]                 fu_flags,
  output logic [7:0]                 fu_operand,
  output logic [1:0][7:0]            fu_depvals,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           perf_st_wait,
  output logic [CNT_W-1:0]           perf_fu_stall
);

  localparam int OCC_W = $clog2(DEPTH) + 1;

  memq_entry_t      wr_entry_s;
  memq_entry_t      head_s;
  logic [OCC_W-1:0] count_s;
  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             is_store_s;
  logic             rob_match_s;
  logic             can_issue_s;
  logic             eval_s;
  logic             issue_now_s;

  memq_state_e      state_r;
  logic             fu_transmit_r;
  logic [3:0]       fu_robid_r;
  logic [7:0]       fu_wbs_r;
  logic [7:0]       fu_flags_r;
  logic [7:0]       fu_operand_r;
  logic [1:0][7:0]  fu_depvals_r;

  // Pack the dispatch payload; MMIO addresses are forwarded unchanged.
  always_comb begin
    wr_entry_s.robid   = in_robid;
    wr_entry_s.wbs     = in_wbs;
    wr_entry_s.flags   = in_flags;
    wr_entry_s.operand = in_operand;
    wr_entry_s.addr    = in_addr;
    wr_entry_s.data    = in_data;
  end

  memq_fifo #(
    .DEPTH (DEPTH),
    .OCC_W (OCC_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .push     (push_s),
    .pop      (issue_now_s),
    .wr_entry (wr_entry_s),
    .rd_entry (head_s),
    .count    (count_s),
    .full     (full_s),
    .empty    (empty_s)
  );

  // Issue decision for the head entry.
  always_comb begin
    push_s      = in_valid && !full_s && !flush;
    is_store_s  = is_store(head_s);
    rob_match_s = rob_head_valid && (rob_head_id == head_s.robid);
    can_issue_s = !fu_busy && (!is_store_s || rob_match_s);
    // COOL also evaluates the next head so back-to-back ops go out every 2 cycles.
    if ((state_r == HEAD) || (state_r == ST_WAIT) || (state_r == COOL)) begin
      eval_s = !empty_s;
    end else begin
      eval_s = 1'b0;
    end
    issue_now_s = eval_s && can_issue_s && !flush;
  end

  // Issue FSM with registered FU payload (payload zero outside the strobe cycle).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= EMPTY;
      fu_transmit_r <= 1'b0;
      fu_robid_r    <= 4'd0;
      fu_wbs_r      <= 8'd0;
      fu_flags_r    <= 8'd0;
      fu_operand_r  <= 8'd0;
      fu_depvals_r  <= 16'd0;
    end else if (flush) begin
      state_r       <= EMPTY;
      fu_transmit_r <= 1'b0;
      fu_robid_r    <= 4'd0;
      fu_wbs_r      <= 8'd0;
      fu_flags_r    <= 8'd0;
      fu_operand_r  <= 8'd0;
      fu_depvals_r  <= 16'd0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (push_s || !empty_s) begin
            state_r <= HEAD;
          end else begin
            state_r <= EMPTY;
          end
        end
        HEAD: begin
          if (issue_now_s) begin
            state_r <= ISSUE;
          end else if (is_store_s && !rob_match_s) begin
            state_r <= ST_WAIT;
          end else begin
            state_r <= HEAD;
          end
        end
        ST_WAIT: begin
          if (issue_now_s) begin
            state_r <= ISSUE;
          end else if (rob_match_s) begin
            // Store is now at ROB head but the FU is busy.
            state_r <= HEAD;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ISSUE: begin
          // FU busy reacts one cycle late, so always idle one cycle.
          state_r <= COOL;
        end
        COOL: begin
          if (issue_now_s) begin
            state_r <= ISSUE;
          end else if (!empty_s || push_s) begin
            state_r <= HEAD;
          end else begin
            state_r <= EMPTY;
          end
        end
        default: state_r <= EMPTY;
      endcase

      fu_transmit_r <= issue_now_s;
      if (issue_now_s) begin
        fu_robid_r    <= head_s.robid;
        fu_wbs_r      <= head_s.wbs;
        fu_flags_r    <= head_s.flags;
        fu_operand_r  <= head_s.operand;
        fu_depvals_r  <= {head_s.addr, head_s.data};
      end else begin
        fu_robid_r    <= 4'd0;
        fu_wbs_r      <= 8'd0;
        fu_flags_r    <= 8'd0;
        fu_operand_r  <= 8'd0;
        fu_depvals_r  <= 16'd0;
      end
    end
  end

`ifdef MEMQ_PERF_EN
  logic [CNT_W-1:0] perf_st_wait_r;
  logic [CNT_W-1:0] perf_fu_stall_r;
  logic             fu_only_block_s;

  // Head would issue were it not for fu_busy.
  always_comb begin
    fu_only_block_s = eval_s && fu_busy && (!is_store_s || rob_match_s);
  end

  // Saturating perf counters; cleared by reset only, never by flush.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_st_wait_r  <= {CNT_W{1'b0}};
      perf_fu_stall_r <= {CNT_W{1'b0}};
    end else begin
      if ((state_r == ST_WAIT) && (perf_st_wait_r != {CNT_W{1'b1}})) begin
        perf_st_wait_r <= perf_st_wait_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (fu_only_block_s && (perf_fu_stall_r != {CNT_W{1'b1}})) begin
        perf_fu_stall_r <= perf_fu_stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign perf_st_wait  = perf_st_wait_r;
  assign perf_fu_stall = perf_fu_stall_r;
`else
  assign perf_st_wait  = {CNT_W{1'b0}};
  assign perf_fu_stall = {CNT_W{1'b0}};
`endif

  assign in_ready    = !full_s;
  assign count       = count_s;
  assign fu_transmit = fu_transmit_r;
  assign fu_robid    = fu_robid_r;
  assign fu_wbs      = fu_wbs_r;
  assign fu_flags    = fu_flags_r;
  assign fu_operand  = fu_operand_r;
  assign fu_depvals  = fu_depvals_r;

endmodule
